tage_t0_upd_sched: RTL and testbench

TAGE_T0_UPD_SCHED -- requirements
Module: tage_t0_upd_sched

---
 rtl/tage_pkg.sv | 29 ++
 rtl/tage_upd_fifo.sv | 58 +++++
 rtl/tage_t0_upd_sched.sv | 154 +++++++++++++++
 tb/tb_tage_t0_upd_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tage_pkg.sv
// Shared types and constants for the TAGE T0 update path.
package tage_pkg;

  localparam int unsigned T0_ENTRIES = 1024;
  localparam int unsigned T0_IDX_W   = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  ghr;
    logic        taken;
    logic [1:0]  pred;
  } upd_entry_t;

  typedef enum logic {
    INIT,
    RUN
  } sched_state_t;

  // Sweep write for one table slot: taken from a 00 counter lands on weakly-not-taken.
  function automatic upd_entry_t init_entry(input logic [T0_IDX_W-1:0] idx);
    upd_entry_t e;
    e.pc    = {24'b0, idx[7:0]};
    e.ghr   = idx[9:8];
    e.taken = 1'b1;
    e.pred  = 2'b00;
    return e;
  endfunction

endpackage

// File: rtl/tage_upd_fifo.sv
// Dual-enqueue, single-dequeue buffer of T0 update entries.
// push_b is only ever asserted together with push_a; entry a is written first.
module tage_upd_fifo
  import tage_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push_a,
  input  upd_entry_t                 data_a,
  input  logic                       push_b,
  input  upd_entry_t                 data_b,
  input  logic                       pop,
  output upd_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  upd_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_b;
  logic [PTR_W-1:0]   rd_ptr;
  logic [1:0]         n_push;

  assign wr_ptr_b = wr_ptr + 1'b1;
  assign n_push   = {1'b0, push_a} + {1'b0, push_b};
  assign head     = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth makes wrap free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_a) mem[wr_ptr]   <= data_a;
      if (push_b) mem[wr_ptr_b] <= data_b;
    end
  end

endmodule

// File: rtl/tage_t0_upd_sched.sv
// T0 update scheduler: sweeps the table to weakly-not-taken after reset/flush,
// then funnels two branch-unit update streams into the single T0 write port.
module tage_t0_upd_sched
  import tage_pkg::*;
#(
  parameter int unsigned T0_ENTRIES = tage_pkg::T0_ENTRIES,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [31:0]                   req0_pc,
  input  logic [1:0]                    req0_ghr,
  input  logic                          req0_taken,
  input  logic [1:0]                    req0_pred,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [31:0]                   req1_pc,
  input  logic [1:0]                    req1_ghr,
  input  logic                          req1_taken,
  input  logic [1:0]                    req1_pred,
  output logic                          upd_valid,
  output logic [31:0]                   upd_pc,
  output logic [1:0]                    upd_ghr,
  output logic                          upd_taken,
  output logic [1:0]                    upd_pred,
  output logic                          init_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [T0_IDX_W-1:0] LAST_IDX = T0_IDX_W'(T0_ENTRIES - 1);

  sched_state_t          state, state_nx;
  logic [T0_IDX_W-1:0]   idx, idx_nx;
  logic                  rr, rr_nx;      // 0: req0 wins a tie, 1: req1 wins
  logic [CNT_W-1:0]      free;
  logic                  acc0, acc1;
  logic                  push_a, push_b, pop;
  upd_entry_t            req0_e, req1_e, push_a_e, push_b_e, head, upd_e;

  assign req0_e = '{pc: req0_pc, ghr: req0_ghr, taken: req0_taken, pred: req0_pred};
  assign req1_e = '{pc: req1_pc, ghr: req1_ghr, taken: req1_taken, pred: req1_pred};

  // Credit comes from the registered count only, so a same-cycle pop never frees a slot.
  assign free = CNT_W'(FIFO_DEPTH) - fifo_count;

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  assign upd_pc    = upd_e.pc;
  assign upd_ghr   = upd_e.ghr;
  assign upd_taken = upd_e.taken;
  assign upd_pred  = upd_e.pred;

  // State, sweep index and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
      rr    <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      rr    <= rr_nx;
    end
  end

  // Next-state, write-port and handshake decode.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    rr_nx      = rr;
    upd_valid  = 1'b0;
    upd_e      = '0;
    init_busy  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    pop        = 1'b0;

    unique case (state)
      INIT: begin
        init_busy = 1'b1;
        if (!flush) begin
          upd_valid = 1'b1;
          upd_e     = init_entry(idx);
          idx_nx    = idx + 1'b1;
          if (idx == LAST_IDX) begin
            state_nx = RUN;
            idx_nx   = '0;
          end
        end
      end
      RUN: begin
        if (!flush) begin
          upd_valid = (fifo_count != '0);
          pop       = upd_valid;
          if (upd_valid) upd_e = head;
          // Each ready looks only at the other side's valid; a lone slot goes to the rr winner.
          req0_ready = req1_valid ? ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !rr))
                                  : (free >= CNT_W'(1));
          req1_ready = req0_valid ? ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && rr))
                                  : (free >= CNT_W'(1));
        end
      end
      default: state_nx = INIT;
    endcase

    if (req0_valid && req1_valid && (acc0 || acc1)) rr_nx = ~rr;

    if (flush) begin
      state_nx = INIT;
      idx_nx   = '0;
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    if (rst) begin
      upd_valid  = 1'b0;
      upd_e      = '0;
      init_busy  = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      pop        = 1'b0;
    end
  end

  // Compact accepted requests onto the FIFO's two write slots, tie winner first.
  always_comb begin
    push_a   = acc0 | acc1;
    push_b   = acc0 & acc1;
    push_b_e = rr ? req0_e : req1_e;
    if (acc0 && acc1) push_a_e = rr ? req1_e : req0_e;
    else if (acc0)    push_a_e = req0_e;
    else              push_a_e = req1_e;
  end

  tage_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .push_a (push_a),
    .data_a (push_a_e),
    .push_b (push_b),
    .data_b (push_b_e),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_tage_t0_upd_sched.sv
// Randomized bench for tage_t0_upd_sched against a queue-based reference model.
module tb_tage_t0_upd_sched;

  localparam int DEPTH   = 4;
  localparam int ENTRIES = 1024;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ghr;
    logic        taken;
    logic [1:0]  pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_pc = '0, req1_pc = '0;
  logic [1:0]  req0_ghr = '0, req1_ghr = '0;
  logic        req0_taken = 1'b0, req1_taken = 1'b0;
  logic [1:0]  req0_pred = '0, req1_pred = '0;
  logic        upd_valid, upd_taken, init_busy;
  logic [31:0] upd_pc;
  logic [1:0]  upd_ghr, upd_pred;
  logic [2:0]  fifo_count;

  tage_t0_upd_sched #(
    .T0_ENTRIES (ENTRIES),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_pc    (req0_pc),
    .req0_ghr   (req0_ghr),
    .req0_taken (req0_taken),
    .req0_pred  (req0_pred),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_pc    (req1_pc),
    .req1_ghr   (req1_ghr),
    .req1_taken (req1_taken),
    .req1_pred  (req1_pred),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_ghr    (upd_ghr),
    .upd_taken  (upd_taken),
    .upd_pred   (upd_pred),
    .init_busy  (init_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit   m_init;
  int   m_idx;
  ent_t q[$];
  bit   m_rr;        // 0: req0 wins a tie
  bit   hold0, hold1;
  int   p_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    if (!hold0) begin
      req0_valid = ($urandom_range(99) < p_valid);
      req0_pc    = $urandom;
      req0_ghr   = 2'($urandom_range(3));
      req0_taken = 1'($urandom_range(1));
      req0_pred  = 2'($urandom_range(3));
    end
    if (!hold1) begin
      req1_valid = ($urandom_range(99) < p_valid);
      req1_pc    = $urandom;
      req1_ghr   = 2'($urandom_range(3));
      req1_taken = 1'($urandom_range(1));
      req1_pred  = 2'($urandom_range(3));
    end
  endtask

  // Called at a negedge with inputs already driven: check, then advance the model at posedge.
  task automatic run_cycle(input bit fl);
    int   free;
    bit   e_r0, e_r1, e_v, a0, a1, v0, v1;
    ent_t e, ent0, ent1;
    flush = fl;
    #1;
    free = DEPTH - q.size();
    e_r0 = 0; e_r1 = 0; e_v = 0;
    e = '{32'd0, 2'd0, 1'b0, 2'd0};
    if (m_init) begin
      if (!fl) begin
        e_v = 1;
        e = '{32'(m_idx % 256), 2'(m_idx / 256), 1'b1, 2'd0};
      end
    end else if (!fl) begin
      e_v = (q.size() != 0);
      if (e_v) e = q[0];
      e_r0 = req1_valid ? (free >= 2 || (free == 1 && !m_rr)) : (free >= 1);
      e_r1 = req0_valid ? (free >= 2 || (free == 1 &&  m_rr)) : (free >= 1);
    end
    check("ready0",     32'(req0_ready), 32'(e_r0));
    check("ready1",     32'(req1_ready), 32'(e_r1));
    check("upd_valid",  32'(upd_valid),  32'(e_v));
    check("upd_pc",     upd_pc,          e.pc);
    check("upd_ghr",    32'(upd_ghr),    32'(e.ghr));
    check("upd_taken",  32'(upd_taken),  32'(e.taken));
    check("upd_pred",   32'(upd_pred),   32'(e.pred));
    check("init_busy",  32'(init_busy),  32'(m_init));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    ent0 = '{req0_pc, req0_ghr, req0_taken, req0_pred};
    ent1 = '{req1_pc, req1_ghr, req1_taken, req1_pred};
    v0 = req0_valid; v1 = req1_valid;
    a0 = v0 && e_r0;
    a1 = v1 && e_r1;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_init = 1; m_idx = 0;
    end else if (m_init) begin
      m_idx++;
      if (m_idx == ENTRIES) begin m_init = 0; m_idx = 0; end
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (a0 && a1) begin
        if (!m_rr) begin q.push_back(ent0); q.push_back(ent1); end
        else       begin q.push_back(ent1); q.push_back(ent0); end
      end else if (a0) q.push_back(ent0);
      else if (a1)     q.push_back(ent1);
      if (v0 && v1 && (a0 || a1)) m_rr = !m_rr;
      if (q.size() > DEPTH) check("model_overflow", 32'(q.size()), 32'(DEPTH));
    end
    hold0 = v0 && !a0;
    hold1 = v1 && !a1;
  endtask

  task automatic step(input bit fl, input bit drv);
    if (drv) drive_reqs();
    run_cycle(fl);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    m_init = 1; m_idx = 0; m_rr = 0; hold0 = 0; hold1 = 0; p_valid = 50;

    // Outputs quiet while reset is held.
    repeat (3) @(negedge clk);
    drive_reqs();
    #1;
    check("rst_upd_valid", 32'(upd_valid),  32'd0);
    check("rst_busy",      32'(init_busy),  32'd0);
    check("rst_ready0",    32'(req0_ready), 32'd0);
    check("rst_ready1",    32'(req1_ready), 32'd0);
    check("rst_upd_pc",    upd_pc,          32'd0);
    check("rst_upd_ghr",   32'(upd_ghr),    32'd0);
    check("rst_upd_taken", 32'(upd_taken),  32'd0);
    check("rst_count",     32'(fifo_count), 32'd0);

    // Full sweep from reset release, requests pending throughout.
    @(negedge clk);
    rst = 1'b0;
    repeat (ENTRIES) step(0, 1);
    #1;
    check("busy_fall", 32'(init_busy), 32'd0);

    // Drain anything held during the sweep.
    p_valid = 0;
    repeat (8) step(0, 1);

    // Single request on an empty FIFO shows up the next cycle.
    hold0 = 0; hold1 = 0;
    req0_valid = 1; req0_pc = 32'h100; req0_ghr = 2'd1; req0_taken = 1; req0_pred = 2'b10;
    req1_valid = 0;
    step(0, 0);
    #1;
    check("dir_valid", 32'(upd_valid), 32'd1);
    check("dir_pc",    upd_pc,         32'h100);
    check("dir_pred",  32'(upd_pred),  32'd2);
    step(0, 1);
    #1;
    check("dir_count", 32'(fifo_count), 32'd0);

    // Both requesters hammering: alternating winners, count settles at 3.
    p_valid = 100;
    repeat (8) step(0, 1);
    #1;
    check("full_count", 32'(fifo_count), 32'd3);

    // Flush with entries buffered, then a second flush mid-sweep.
    step(1, 1);
    p_valid = 30;
    repeat (50) step(0, 1);
    step(1, 1);
    repeat (ENTRIES) step(0, 1);

    // Mixed random traffic in RUN.
    p_valid = 60;
    repeat (400) step(0, 1);

    // Asynchronous reset in the middle of a sweep.
    p_valid = 40;
    step(1, 1);
    guard = 0;
    while (m_idx != 500 && guard < 2000) begin
      step(0, 1);
      guard++;
    end
    check("reach_idx500", 32'(m_idx), 32'd500);
    #2;
    rst = 1'b1;
    #1;
    check("arst_upd_valid", 32'(upd_valid),  32'd0);
    check("arst_busy",      32'(init_busy),  32'd0);
    check("arst_ready0",    32'(req0_ready), 32'd0);
    check("arst_upd_pc",    upd_pc,          32'd0);
    check("arst_count",     32'(fifo_count), 32'd0);
    q.delete();
    m_init = 1; m_idx = 0; m_rr = 0; hold0 = 0; hold1 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (ENTRIES + 40) step(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
